// File: rtl/mdu_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: opcodes, FSM states, iteration count.
// Also holds the signed-magnitude helper used when operands are latched.
package mdu_pkg;

  localparam int MDU_ITER = 32;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'b000,
    MDU_MULTU = 3'b001,
    MDU_DIV   = 3'b010,
    MDU_DIVU  = 3'b011,
    MDU_MTHI  = 3'b100,
    MDU_MTLO  = 3'b101
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_e;

  function automatic logic [31:0] mag32(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One combinational iteration: shift-add for multiply, restoring shift-subtract for divide.
// Zero latency; no flow control, the caller decides when the result is registered.
module mdu_step (
  input  logic        is_div_i,
  input  logic [63:0] acc_i,
  input  logic [31:0] opnd_i,
  output logic [63:0] acc_o
);

  logic [32:0] sum;
  logic [32:0] trial;

  always_comb begin
    sum   = {1'b0, acc_i[63:32]} + (acc_i[0] ? {1'b0, opnd_i} : 33'd0);
    // Shifted partial remainder minus divisor; bit 32 set means the trial borrowed.
    trial = acc_i[63:31] - {1'b0, opnd_i};
    if (!is_div_i) begin
      acc_o = {sum, acc_i[31:1]};
    end else if (!trial[32]) begin
      acc_o = {trial[31:0], acc_i[30:0], 1'b1};
    end else begin
      acc_o = {acc_i[62:0], 1'b0};
    end
  end

endmodule

// File: rtl/mdu_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO; HI/LO and DONE update ITER+1 edges after START.
// No backpressure: START is ignored while BUSY, so control must stall the pipeline on BUSY.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int ITER = MDU_ITER
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        START,
  input  logic [2:0]  OP,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        BUSY,
  output logic        DONE
);

  mdu_state_e  state_q;
  logic [5:0]  cnt_q;
  logic [63:0] acc_q;
  logic [63:0] acc_step_d;
  logic [31:0] opnd_q;
  logic [31:0] a_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        is_div_q;
  logic        neg_q;
  logic        rneg_q;
  logic        dz_q;
  logic        busy_q;
  logic        done_q;

  logic        sgn_d;
  logic [63:0] prod_d;
  logic [31:0] quo_d;
  logic [31:0] rem_d;
  logic [31:0] fix_hi_d;
  logic [31:0] fix_lo_d;

  mdu_step u_step (
    .is_div_i (is_div_q),
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .acc_o    (acc_step_d)
  );

  assign sgn_d = (OP == MDU_MULT) || (OP == MDU_DIV);

  // Sign correction applied at the FIX edge; divide-by-zero bypasses the datapath result.
  always_comb begin
    prod_d   = neg_q  ? (~acc_q + 64'd1)        : acc_q;
    quo_d    = neg_q  ? (~acc_q[31:0] + 32'd1)  : acc_q[31:0];
    rem_d    = rneg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
    fix_hi_d = prod_d[63:32];
    fix_lo_d = prod_d[31:0];
    if (is_div_q) begin
      fix_hi_d = dz_q ? a_q          : rem_d;
      fix_lo_d = dz_q ? 32'hFFFFFFFF : quo_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 6'd0;
      acc_q    <= 64'd0;
      opnd_q   <= 32'd0;
      a_q      <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            case (OP)
              MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                a_q      <= A;
                is_div_q <= OP[1];
                dz_q     <= OP[1] && (B == 32'd0);
                neg_q    <= sgn_d && (A[31] ^ B[31]);
                rneg_q   <= sgn_d && OP[1] && A[31];
                // Divide shifts the dividend through acc; multiply shifts the multiplier.
                acc_q    <= {32'd0, OP[1] ? mag32(A, sgn_d) : mag32(B, sgn_d)};
                opnd_q   <= OP[1] ? mag32(B, sgn_d) : mag32(A, sgn_d);
                cnt_q    <= 6'd0;
                busy_q   <= 1'b1;
                state_q  <= ST_RUN;
              end
              MDU_MTHI: hi_q <= A;
              MDU_MTLO: lo_q <= A;
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          acc_q <= acc_step_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'(ITER - 1)) state_q <= ST_FIX;
        end
        ST_FIX: begin
          hi_q    <= fix_hi_d;
          lo_q    <= fix_lo_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          cnt_q   <= 6'd0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign HI   = hi_q;
  assign LO   = lo_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule
